// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port, variable-latency memory between the
//               instruction-fetch port (requester 0) and the load/store data
//               port (requester 1). Each access is sequenced as grant, memory
//               wait and acknowledge. Features round-robin fairness, a
//               bus-timeout watchdog and a combinational CPU stall request.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk_in,
  input  logic          reset,
  // instruction-fetch port (requester 0)
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  // load/store data port (requester 1)
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  // memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  // CPU stall request
  output logic          stall
);

  // Last BUSY cycle index (counter value) before the watchdog gives up.
  localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic          owner_q;       // 0 = fetch, 1 = data
  logic          last_grant_q;  // requester served most recently
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [7:0]    tmo_cnt_q;
  logic          mem_en_q;
  logic          if_ack_q;
  logic          if_err_q;
  logic          d_ack_q;
  logic          d_err_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;

  logic          grant_d;
  logic          owner_d;

  // Arbitration decision: single requester wins outright, contention
  // goes to whichever requester was not served last.
  always_comb begin
    grant_d = 1'b0;
    owner_d = 1'b0;
    if (if_req && d_req) begin
      grant_d = 1'b1;
      owner_d = ~last_grant_q;
    end else if (if_req) begin
      grant_d = 1'b1;
      owner_d = 1'b0;
    end else if (d_req) begin
      grant_d = 1'b1;
      owner_d = 1'b1;
    end
  end

  // Access sequencer: grant in IDLE, wait for ready or watchdog in BUSY,
  // pulse ack/err during the single DONE cycle.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      tmo_cnt_q    <= '0;
      mem_en_q     <= 1'b0;
      if_ack_q     <= 1'b0;
      if_err_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      // completion flags are single-cycle pulses
      if_ack_q <= 1'b0;
      if_err_q <= 1'b0;
      d_ack_q  <= 1'b0;
      d_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_d) begin
            owner_q      <= owner_d;
            last_grant_q <= owner_d;
            we_q         <= owner_d & d_we;
            addr_q       <= owner_d ? d_addr : if_addr;
            wdata_q      <= owner_d ? d_wdata : '0;
            tmo_cnt_q    <= '0;
            mem_en_q     <= 1'b1;
            state_q      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            // ready wins even on the cycle the watchdog would expire
            mem_en_q <= 1'b0;
            state_q  <= ST_DONE;
            if (owner_q) begin
              d_ack_q <= 1'b1;
              if (!we_q) begin
                d_rdata_q <= mem_rdata;
              end
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= mem_rdata;
            end
          end else if (tmo_cnt_q == C_TMO_LAST) begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
            mem_en_q  <= 1'b0;
            state_q   <= ST_DONE;
            if (owner_q) begin
              d_err_q <= 1'b1;
            end else begin
              if_err_q <= 1'b1;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          mem_en_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_en_q & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

  // A requester stalls the CPU until its completion pulse is seen.
  assign stall = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: directed scenarios
//               plus randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk_in = 1'b0;
  logic          reset  = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          if_err;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          d_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          stall;

  int total = 0;
  int bad   = 0;

  // model of the last value each port has legitimately received
  logic [DW-1:0] exp_if_rd = '0;
  logic [DW-1:0] exp_d_rd  = '0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall     (stall)
  );

  always #5 clk_in = ~clk_in;

  // hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic drop_all();
    if_req    = 1'b0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    drop_all();
    reset = 1'b0;
    repeat (2) step();
    total++;
    if ({mem_en, mem_we, if_ack, if_err, d_ack, d_err, stall} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 0000000",
               {mem_en, mem_we, if_ack, if_err, d_ack, d_err, stall});
    end
    total++;
    if ({if_rdata, d_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata, d_rdata);
    end
    total++;
    if ({mem_addr, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_membus: got %h/%h want 0/0", mem_addr, mem_wdata);
    end
    reset = 1'b1;
    step();
    total++;
    if (mem_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: mem_en got %b want 0", mem_en);
    end
  endtask

  task automatic test_single_fetch();
    if_req  = 1'b1;
    if_addr = 32'h100;
    step();
    total++;
    if ({mem_en, mem_we, mem_addr, stall, if_ack} !== {1'b1, 1'b0, 32'h100, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL fetch_busy: en=%b we=%b addr=%h stall=%b ack=%b want 1 0 100 1 0",
               mem_en, mem_we, mem_addr, stall, if_ack);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h8C010004;
    step();
    total++;
    if ({mem_en, if_ack, if_err, stall} !== 4'b0100) begin
      bad++;
      $display("FAIL fetch_done: en/ack/err/stall got %b want 0100",
               {mem_en, if_ack, if_err, stall});
    end
    total++;
    if (if_rdata !== 32'h8C010004) begin
      bad++;
      $display("FAIL fetch_rdata: got %h want 8c010004", if_rdata);
    end
    exp_if_rd = 32'h8C010004;
    if_req    = 1'b0;
    mem_ready = 1'b0;
    step();
    total++;
    if ({if_ack, stall, if_rdata} !== {1'b0, 1'b0, exp_if_rd}) begin
      bad++;
      $display("FAIL fetch_hold: ack=%b stall=%b rdata=%h want 0 0 %h",
               if_ack, stall, if_rdata, exp_if_rd);
    end
  endtask

  task automatic test_store_waits();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h2000;
    d_wdata = 32'hDEADBEEF;
    for (int k = 1; k <= 4; k++) begin
      step();
      total++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h2000, 32'hDEADBEEF}) begin
        bad++;
        $display("FAIL store_bus[%0d]: en=%b we=%b addr=%h wdata=%h want 1 1 2000 deadbeef",
                 k, mem_en, mem_we, mem_addr, mem_wdata);
      end
      mem_ready = (k == 4);
      mem_rdata = 32'h12345678;
    end
    step();
    total++;
    if ({d_ack, d_err, if_ack, mem_en} !== 4'b1000) begin
      bad++;
      $display("FAIL store_done: ack/err/if_ack/en got %b want 1000",
               {d_ack, d_err, if_ack, mem_en});
    end
    total++;
    if ({d_rdata, if_rdata} !== {exp_d_rd, exp_if_rd}) begin
      bad++;
      $display("FAIL store_rdata: got %h/%h want %h/%h", d_rdata, if_rdata, exp_d_rd, exp_if_rd);
    end
    drop_all();
    step();
  endtask

  task automatic test_contention();
    int ack_cyc[$];
    int ack_who[$];
    reset     = 1'b0;
    if_req    = 1'b1;
    if_addr   = 32'hA0;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'hB0;
    mem_ready = 1'b1;
    mem_rdata = 32'hC0DE0000;
    step();
    reset = 1'b1;
    exp_if_rd = '0;
    exp_d_rd  = '0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (if_ack === 1'b1) begin
        ack_cyc.push_back(c);
        ack_who.push_back(0);
        exp_if_rd = mem_rdata;
        total++;
        if (if_rdata !== mem_rdata) begin
          bad++;
          $display("FAIL cont_if_rdata: got %h want %h", if_rdata, mem_rdata);
        end
      end
      if (d_ack === 1'b1) begin
        ack_cyc.push_back(c);
        ack_who.push_back(1);
        exp_d_rd = mem_rdata;
        total++;
        if (d_rdata !== mem_rdata) begin
          bad++;
          $display("FAIL cont_d_rdata: got %h want %h", d_rdata, mem_rdata);
        end
      end
      mem_rdata = 32'hC0DE0000 + 32'(c);
    end
    total++;
    if (ack_cyc.size() != 4) begin
      bad++;
      $display("FAIL cont_count: got %0d acks want 4", ack_cyc.size());
    end
    for (int i = 0; i < ack_cyc.size() && i < 4; i++) begin
      total++;
      if (ack_cyc[i] != 2 + 3 * i || ack_who[i] != i % 2) begin
        bad++;
        $display("FAIL cont_order[%0d]: got cycle %0d port %0d want cycle %0d port %0d",
                 i, ack_cyc[i], ack_who[i], 2 + 3 * i, i % 2);
      end
    end
    drop_all();
    repeat (3) step();
  endtask

  task automatic test_timeout();
    int en_cnt  = 0;
    int err_cnt = 0;
    int ack_cnt = 0;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h3000;
    mem_ready = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (mem_en === 1'b1) en_cnt++;
      if (d_err === 1'b1) begin
        err_cnt++;
        d_req = 1'b0;
      end
      if (d_ack === 1'b1 || if_ack === 1'b1 || if_err === 1'b1) ack_cnt++;
      mem_rdata = $urandom;
    end
    total++;
    if (en_cnt != TO) begin
      bad++;
      $display("FAIL tmo_en_cycles: got %0d want %0d", en_cnt, TO);
    end
    total++;
    if (err_cnt != 1 || ack_cnt != 0) begin
      bad++;
      $display("FAIL tmo_pulses: err=%0d other=%0d want 1 0", err_cnt, ack_cnt);
    end
    total++;
    if ({d_rdata, mem_en} !== {exp_d_rd, 1'b0}) begin
      bad++;
      $display("FAIL tmo_after: rdata=%h en=%b want %h 0", d_rdata, mem_en, exp_d_rd);
    end
  endtask

  task automatic test_ready_on_timeout_edge();
    int busy = 0;
    bit done = 0;
    if_req    = 1'b1;
    if_addr   = 32'h400;
    mem_ready = 1'b0;
    for (int c = 1; c <= 30 && !done; c++) begin
      step();
      if (mem_en === 1'b1) begin
        busy++;
        if (busy == TO) begin
          mem_ready = 1'b1;
          mem_rdata = 32'hFACE0015;
        end
      end else if (busy > 0) begin
        done = 1;
        total++;
        if ({if_ack, if_err, if_rdata} !== {2'b10, 32'hFACE0015} || busy != TO) begin
          bad++;
          $display("FAIL tmo_edge: ack=%b err=%b rdata=%h busy=%0d want 1 0 face0015 %0d",
                   if_ack, if_err, if_rdata, busy, TO);
        end
        exp_if_rd = 32'hFACE0015;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL tmo_edge_wait: no completion seen, busy=%0d", busy);
    end
    drop_all();
    step();
  endtask

  task automatic test_reset_mid_busy();
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h500;
    mem_ready = 1'b0;
    repeat (2) step();
    total++;
    if (mem_en !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_pre: mem_en got %b want 1", mem_en);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({mem_en, if_ack, if_err, d_ack, d_err, if_rdata} !== '0) begin
      bad++;
      $display("FAIL rst_mid_now: en/ack/err=%b if_rdata=%h want 0",
               {mem_en, if_ack, if_err, d_ack, d_err}, if_rdata);
    end
    exp_if_rd = '0;
    exp_d_rd  = '0;
    d_req = 1'b0;
    step();
    reset   = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h600;
    d_req   = 1'b1;
    d_addr  = 32'h700;
    step();
    total++;
    if ({mem_en, mem_addr} !== {1'b1, 32'h600}) begin
      bad++;
      $display("FAIL rst_mid_first: en=%b addr=%h want 1 600", mem_en, mem_addr);
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h11112222;
    step();
    total++;
    if ({if_ack, d_ack, if_rdata} !== {2'b10, 32'h11112222}) begin
      bad++;
      $display("FAIL rst_mid_ack: if_ack=%b d_ack=%b rdata=%h want 1 0 11112222",
               if_ack, d_ack, if_rdata);
    end
    exp_if_rd = 32'h11112222;
    if_req = 1'b0;
    step();
    step();
    total++;
    if ({mem_en, mem_addr} !== {1'b1, 32'h700}) begin
      bad++;
      $display("FAIL rst_mid_second: en=%b addr=%h want 1 700", mem_en, mem_addr);
    end
    mem_rdata = 32'h33334444;
    step();
    total++;
    if ({d_ack, d_rdata, if_rdata} !== {1'b1, 32'h33334444, exp_if_rd}) begin
      bad++;
      $display("FAIL rst_mid_d: ack=%b d_rdata=%h if_rdata=%h want 1 33334444 %h",
               d_ack, d_rdata, if_rdata, exp_if_rd);
    end
    exp_d_rd = 32'h33334444;
    drop_all();
    step();
  endtask

  // Random traffic: each requester raises requests at random, memory answers
  // after a random number of wait states (sometimes past the watchdog).
  task automatic test_random();
    bit            pend[2];
    bit            snap[2];
    logic [AW-1:0] ra[2];
    bit            rwe[2];
    logic [DW-1:0] rwd[2];
    bit            active = 0;
    bit            own = 0;
    bit            last = 1;
    bit            ok;
    bit            done_now;
    bit            expect_grant = 0;
    bit            exp_stall;
    int            busy = 0;
    int            w = 0;
    int            txn = 0;
    logic [DW-1:0] rd_drv = '0;
    logic [3:0]    exp_vec;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; snap[i] = 0; ra[i] = '0; rwe[i] = 0; rwd[i] = '0;
    end
    drop_all();
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_if_rd = '0;
    exp_d_rd  = '0;
    for (int c = 0; c < 4000 && txn < 60; c++) begin
      step();
      done_now = 0;
      exp_vec  = 4'b0000;
      if (expect_grant) begin
        total++;
        if (mem_en !== 1'b1) begin
          bad++;
          $display("FAIL rand_gap: mem_en got %b want 1 one cycle after idle with request", mem_en);
        end
      end
      if (mem_en === 1'b1 && !active) begin
        if (!snap[0] && !snap[1]) begin
          total++;
          bad++;
          $display("FAIL rand_spurious: grant with no request at cycle %0d", c);
        end
        own    = (snap[0] && snap[1]) ? !last : snap[1];
        last   = own;
        active = 1;
        busy   = 0;
        w      = $urandom_range(0, TO + 2);
      end
      if (mem_en === 1'b1 && active) begin
        busy++;
        total++;
        if ({mem_we, mem_addr, (own && rwe[1]) ? mem_wdata : 32'h0} !==
            {own & rwe[1], ra[own], (own && rwe[1]) ? rwd[1] : 32'h0}) begin
          bad++;
          $display("FAIL rand_bus: port %0d we=%b addr=%h wdata=%h want %b %h %h", own,
                   mem_we, mem_addr, mem_wdata, own & rwe[1], ra[own], rwd[1]);
        end
        mem_ready = (busy == w + 1);
        rd_drv    = $urandom;
        mem_rdata = rd_drv;
      end else if (active) begin
        ok = (w < TO);
        total++;
        if (busy != (ok ? w + 1 : TO)) begin
          bad++;
          $display("FAIL rand_len: busy cycles got %0d want %0d (waits %0d)",
                   busy, ok ? w + 1 : TO, w);
        end
        if (ok && !own) exp_if_rd = rd_drv;
        if (ok && own && !rwe[1]) exp_d_rd = rd_drv;
        exp_vec   = own ? {2'b00, ok, !ok} : {ok, !ok, 2'b00};
        done_now  = 1;
        active    = 0;
        txn++;
        mem_ready = $urandom_range(0, 1);
        mem_rdata = $urandom;
      end else begin
        mem_ready = $urandom_range(0, 1);
        mem_rdata = $urandom;
      end
      total++;
      if ({if_ack, if_err, d_ack, d_err} !== exp_vec) begin
        bad++;
        $display("FAIL rand_pulse: if_ack/if_err/d_ack/d_err got %b want %b at cycle %0d",
                 {if_ack, if_err, d_ack, d_err}, exp_vec, c);
      end
      total++;
      if ({if_rdata, d_rdata} !== {exp_if_rd, exp_d_rd}) begin
        bad++;
        $display("FAIL rand_rdata: got %h/%h want %h/%h", if_rdata, d_rdata, exp_if_rd, exp_d_rd);
      end
      exp_stall = (pend[0] && !exp_vec[3]) || (pend[1] && !exp_vec[1]);
      total++;
      if (stall !== exp_stall) begin
        bad++;
        $display("FAIL rand_stall: got %b want %b at cycle %0d", stall, exp_stall, c);
      end
      if (done_now) pend[own] = 0;
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          ra[i]   = $urandom;
          rwe[i]  = (i == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
          rwd[i]  = $urandom;
        end
      end
      if_req  = pend[0];
      if_addr = ra[0];
      d_req   = pend[1];
      d_we    = rwe[1];
      d_addr  = ra[1];
      d_wdata = rwd[1];
      snap[0] = pend[0];
      snap[1] = pend[1];
      expect_grant = (mem_en === 1'b0) && !done_now && (pend[0] || pend[1]);
    end
    total++;
    if (txn < 60) begin
      bad++;
      $display("FAIL rand_progress: completed %0d transactions want 60", txn);
    end
    drop_all();
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_waits();
    test_contention();
    test_timeout();
    test_ready_on_timeout_edge();
    test_reset_mid_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between the CPU instruction-fetch port (requester 0) and the load/store data port (requester 1).
- Sits between the cpu core datapath and the memory block.
- Sequences each access as request, memory wait, and acknowledge.
- Provides round-robin fairness, a bus-timeout watchdog and a CPU stall signal.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 15, maximum wait cycles for mem_ready before abort (range 1..255).

Ports:
- clk_in  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held high until if_ack or if_err.
- if_addr  input  AW  fetch address.
- if_ack  output  1  one-cycle fetch-complete pulse.
- if_rdata  output  DW  fetched word; valid while if_ack=1.
- if_err  output  1  one-cycle fetch-timeout pulse.
- d_req  input  1  data request; held until d_ack or d_err.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  AW  data address.
- d_wdata  input  DW  store data.
- d_ack  output  1  one-cycle data-complete pulse.
- d_rdata  output  DW  load data; valid while d_ack=1.
- d_err  output  1  one-cycle data-timeout pulse.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data; valid when mem_ready=1.
- mem_ready  input  1  memory completes the access this cycle.
- stall  output  1  CPU stall request.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; last_grant=1 (so fetch wins first contention).
  - All outputs 0, including rdata buses and the timeout counter.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If only one req is high, grant it.
  - If both are high, grant the requester not equal to last_grant (round-robin).
  - On grant, latch addr/we/wdata into internal registers, set owner and last_grant, clear timeout counter, go to BUSY.
  - Requests are sampled only in IDLE.
- BUSY:
  - mem_en=1. mem_we = latched we (always 0 for fetch). mem_addr/mem_wdata driven from the latched registers, stable for the whole access.
  - mem_ready=1 at an edge: capture mem_rdata into the owner's rdata register, go to DONE, deassert mem_en next cycle.
  - Otherwise increment the timeout counter.
  - Counter reaches TIMEOUT with mem_ready still 0: go to DONE with error flag set; mem_rdata is not captured.
  - mem_ready arriving on the same edge the counter hits TIMEOUT counts as success (ready has priority).
- DONE (exactly one cycle):
  - Owner's ack=1, or owner's err=1 on timeout; never both.
  - mem_en=0; requests ignored.
  - Next state is IDLE.
  - Minimum access is 3 cycles: grant edge, BUSY cycle with ready, DONE cycle. Idle gap before the next grant is 1 cycle.
- rdata of the owner holds its value after DONE until that owner's next completion. The non-owner's rdata is unchanged. For stores, d_rdata is unchanged.
- stall = (if_req & ~if_ack) | (d_req & ~d_ack); combinational.
- A requester dropping req while in BUSY:
  - The access still completes to memory; no abort of the memory transaction.
  - ack/err is still pulsed in DONE.
- Writes are never retried after timeout; the CPU handles d_err.
- Reset asserted mid-access: immediate return to IDLE, mem_en=0, no ack/err pulse.
- Fairness:
  - With both requesters held high continuously, grants alternate 0,1,0,1.
  - No requester waits more than one foreign access.

Test Plan:
- Single fetch, zero wait: reset released; if_req=1, if_addr=0x100; mem_ready=1 on the first BUSY cycle with mem_rdata=0x8C010004 -> mem_en high 1 cycle with mem_addr=0x100, mem_we=0; if_ack pulses 1 cycle later with if_rdata=0x8C010004; stall low after ack.
- Store with 3 wait states: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF; mem_ready at the 4th BUSY cycle -> mem_en/mem_we/mem_addr/mem_wdata held stable for 4 cycles; d_ack 1 cycle; d_rdata unchanged.
- Contention: if_req and d_req both high from reset, memory zero-wait -> grant order fetch, data, fetch, data; each ack 3 cycles apart.
- Timeout: d_req load with TIMEOUT=15, mem_ready tied 0 -> mem_en high exactly 15 cycles; d_err 1 pulse; d_ack never; d_rdata unchanged; arbiter back in IDLE.
- Ready on the timeout edge: mem_ready asserted on BUSY cycle 15 -> ack (not err) with the captured data.
- Reset mid-BUSY: reset=0 during the 2nd wait cycle -> mem_en, ack, err all 0 immediately; after release, a new if_req is served normally with fetch first.
